// File: rtl/dlx_vmac_pkg.sv
// dlx_vmac_pkg: state encoding and default widths shared by the VDOT sequencer
package dlx_vmac_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W = 8;
    localparam int DEF_ADDR_STEP = 1;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        ACC  = 3'd3,
        DONE = 3'd4
    } vmac_state_t;
endpackage

// File: rtl/dlx_vmac_agu.sv
// dlx_vmac_agu: latched vector bases, element index counter and operand address mux
module dlx_vmac_agu
    import dlx_vmac_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic              inc,
    input  logic              sel_b,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              first,
    output logic              last
);
    logic [ADDR_W-1:0] base_a_q, base_b_q;
    logic [LEN_W-1:0] len_q, idx;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            base_a_q <= '0;
            base_b_q <= '0;
            len_q <= '0;
            idx <= '0;
        end else if (load) begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            len_q <= len;
            idx <= '0;
        end else if (inc) begin
            idx <= idx + LEN_W'(1);
        end
    end
    // modulo-2^ADDR_W arithmetic; wrap past the top of memory is intentional
    assign addr = (sel_b ? base_b_q : base_a_q) + ADDR_W'(idx) * ADDR_W'(ADDR_STEP);
    assign first = idx == '0;
    assign last = idx + LEN_W'(1) == len_q;
endmodule

// File: rtl/dlx_vmac_seq.sv
// dlx_vmac_seq: VDOT multiply-accumulate sequencer; define DLX_VMAC_ABORT_EN for the abort input
module dlx_vmac_seq
    import dlx_vmac_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
`ifdef DLX_VMAC_ABORT_EN
    input  logic              abort,
`endif
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    input  logic              busy,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              MR,
    output logic [DATA_W-1:0] opA,
    output logic [DATA_W-1:0] opB,
    output logic              MAC_EN,
    output logic              MAC_RST,
    output logic              seq_busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        STATE_o
);
    vmac_state_t state, state_nx;
    logic err_q, err_nx, load, cap_a, cap_b, first, last, ab;
    logic [ADDR_W-1:0] agu_addr;
`ifdef DLX_VMAC_ABORT_EN
    assign ab = abort;
`else
    assign ab = 1'b0;
`endif
    dlx_vmac_agu #(
        .ADDR_W(ADDR_W),
        .LEN_W(LEN_W),
        .ADDR_STEP(ADDR_STEP)
    ) u_agu (
        .CLK(CLK),
        .RESET(RESET),
        .load(load),
        .inc(MAC_EN),
        .sel_b(state == RDB),
        .base_a(base_a),
        .base_b(base_b),
        .len(len),
        .addr(agu_addr),
        .first(first),
        .last(last)
    );
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            err_q <= 1'b0;
            opA <= '0;
            opB <= '0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            if (cap_a) opA <= mem_data;
            if (cap_b) opB <= mem_data;
        end
    end
    always_comb begin
        state_nx = state;
        err_nx = err_q;
        load = 1'b0;
        case (state)
            IDLE: begin
                load = start;
                state_nx = !start ? IDLE : len == '0 ? DONE : RDA;
                err_nx = start ? len == '0 : err_q;
            end
            RDA: begin
                state_nx = ab ? DONE : busy ? RDA : RDB;
                err_nx = ab;
            end
            RDB: begin
                state_nx = ab ? DONE : busy ? RDB : ACC;
                err_nx = ab;
            end
            ACC: begin
                state_nx = (last || ab) ? DONE : RDA;
                err_nx = ab;
            end
            default: state_nx = IDLE;
        endcase
    end
    // an abort takes priority over a read completing in the same cycle
    assign cap_a = state == RDA && !busy && !ab;
    assign cap_b = state == RDB && !busy && !ab;
    assign MR = state == RDA || state == RDB;
    assign mem_addr = MR ? agu_addr : '0;
    assign MAC_EN = state == ACC;
    assign MAC_RST = MAC_EN && first;
    assign seq_busy = state != IDLE;
    assign done = state == DONE;
    assign err = done && err_q;
    assign STATE_o = state;
endmodule

// File: tb/tb_dlx_vmac_seq.sv
// tb_dlx_vmac_seq: cycle-by-cycle schedule model of the VDOT sequencer with randomized vectors and waits
module tb_dlx_vmac_seq;
    localparam int AW = 32, DW = 32, LW = 8, STEP = 1;
    logic CLK = 1'b0, RESET = 1'b1, start = 1'b0, busy = 1'b0;
    logic [AW-1:0] base_a = '0, base_b = '0;
    logic [LW-1:0] len = '0;
    logic [DW-1:0] mem_data = '0;
`ifdef DLX_VMAC_ABORT_EN
    logic abort = 1'b0;
`endif
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] opA, opB;
    logic MR, MAC_EN, MAC_RST, seq_busy, done, err;
    logic [2:0] STATE_o;
    int checks = 0, errors = 0;

    typedef struct {
        logic [2:0] st;
        logic busy, mr, mac_en, mac_rst, done, err;
        logic [AW-1:0] addr;
        logic [DW-1:0] a, b;
    } step_t;

    dlx_vmac_seq dut (
        .CLK(CLK),
        .RESET(RESET),
        .start(start),
`ifdef DLX_VMAC_ABORT_EN
        .abort(abort),
`endif
        .base_a(base_a),
        .base_b(base_b),
        .len(len),
        .busy(busy),
        .mem_data(mem_data),
        .mem_addr(mem_addr),
        .MR(MR),
        .opA(opA),
        .opB(opB),
        .MAC_EN(MAC_EN),
        .MAC_RST(MAC_RST),
        .seq_busy(seq_busy),
        .done(done),
        .err(err),
        .STATE_o(STATE_o)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".state"}, 64'(STATE_o), 64'd0);
        chk({tag, ".seq_busy"}, 64'(seq_busy), 64'd0);
        chk({tag, ".MR"}, 64'(MR), 64'd0);
        chk({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, ".MAC_EN"}, 64'(MAC_EN), 64'd0);
        chk({tag, ".MAC_RST"}, 64'(MAC_RST), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'd0);
    endtask

    task automatic step_chk(input step_t e);
        chk("state", 64'(STATE_o), 64'(e.st));
        chk("seq_busy", 64'(seq_busy), 64'd1);
        chk("MR", 64'(MR), 64'(e.mr));
        chk("mem_addr", 64'(mem_addr), e.mr ? 64'(e.addr) : 64'd0);
        chk("MAC_EN", 64'(MAC_EN), 64'(e.mac_en));
        chk("MAC_RST", 64'(MAC_RST), 64'(e.mac_rst));
        chk("done", 64'(done), 64'(e.done));
        chk("err", 64'(err), 64'(e.err));
        if (e.mac_en) begin
            chk("opA", 64'(opA), 64'(e.a));
            chk("opB", 64'(opB), 64'(e.b));
        end
    endtask

    // wfix >= 0 holds busy that many cycles on every read; -1 picks 0..2 at random
    task automatic run_vec(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input logic [LW-1:0] ln, input int wfix);
        step_t q[$];
        step_t e;
        int w;
        @(negedge CLK);
        idle_chk("idle");
        start = 1'b1;
        base_a = ba;
        base_b = bb;
        len = ln;
        busy = 1'($urandom_range(0, 1));
        mem_data = $urandom;
        for (int i = 0; i < int'(ln); i++) begin
            for (int s = 0; s < 2; s++) begin
                w = wfix >= 0 ? wfix : int'($urandom_range(0, 2));
                e = '{default: '0};
                e.st = 3'(s + 1);
                e.mr = 1'b1;
                e.addr = (s == 1 ? bb : ba) + AW'(i * STEP);
                e.busy = 1'b1;
                repeat (w) q.push_back(e);
                e.busy = 1'b0;
                q.push_back(e);
            end
            e = '{default: '0};
            e.st = 3'd3;
            e.busy = 1'($urandom_range(0, 1));
            e.mac_en = 1'b1;
            e.mac_rst = i == 0;
            e.a = mem(ba + AW'(i * STEP));
            e.b = mem(bb + AW'(i * STEP));
            q.push_back(e);
        end
        e = '{default: '0};
        e.st = 3'd4;
        e.busy = 1'($urandom_range(0, 1));
        e.done = 1'b1;
        e.err = ln == '0;
        q.push_back(e);
        foreach (q[k]) begin
            @(negedge CLK);
            start = k == q.size() - 1 ? 1'b0 : 1'($urandom_range(0, 1));
            base_a = $urandom;
            base_b = $urandom;
            len = LW'($urandom);
            busy = q[k].busy;
            mem_data = q[k].busy ? $urandom : mem(mem_addr);
            step_chk(q[k]);
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        idle_chk("reset");
        chk("reset.opA", 64'(opA), 64'd0);
        chk("reset.opB", 64'(opB), 64'd0);
        RESET = 1'b0;
        run_vec(32'h100, 32'h200, 8'd3, 0);
        run_vec(32'h10, 32'h20, 8'd2, 2);
        run_vec(32'h30, 32'h40, 8'd0, 0);
        run_vec(32'hFFFF_FFFF, 32'h50, 8'd2, 1);
        @(negedge CLK);
        idle_chk("pre_rst");
        start = 1'b1;
        base_a = 32'h300;
        base_b = 32'h400;
        len = 8'd2;
        busy = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            start = 1'b0;
            mem_data = mem(mem_addr);
        end
        chk("rst.in_rdb2", 64'(STATE_o), 64'd2);
        chk("rst.addr_b2", 64'(mem_addr), 64'h401);
        RESET = 1'b1;
        @(negedge CLK);
        idle_chk("mid_rst");
        chk("mid_rst.opA", 64'(opA), 64'd0);
        chk("mid_rst.opB", 64'(opB), 64'd0);
        RESET = 1'b0;
        run_vec(32'h500, 32'h600, 8'd1, 0);
`ifdef DLX_VMAC_ABORT_EN
        @(negedge CLK);
        idle_chk("pre_abort");
        start = 1'b1;
        base_a = 32'h700;
        base_b = 32'h800;
        len = 8'd3;
        @(negedge CLK);
        start = 1'b0;
        busy = 1'b1;
        abort = 1'b1;
        chk("abort.state", 64'(STATE_o), 64'd1);
        chk("abort.MR", 64'(MR), 64'd1);
        @(negedge CLK);
        abort = 1'b0;
        chk("abort.state_done", 64'(STATE_o), 64'd4);
        chk("abort.done", 64'(done), 64'd1);
        chk("abort.err", 64'(err), 64'd1);
        busy = 1'b0;
`endif
        repeat (25) run_vec($urandom, $urandom, LW'($urandom_range(0, 6)), -1);
        @(negedge CLK);
        idle_chk("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dlx_vmac_seq.md
# dlx_vmac_seq

Multi-cycle vector multiply-accumulate sequencer for the extended DLX datapath. The main control FSM hands off a VDOT instruction with a single `start` pulse. The sequencer then streams `len` operand pairs from memory over the existing `MR`/`busy` handshake, drives the MAC unit's `MAC_EN`/`MAC_RST` strobes, and pulses `done` so the control FSM can write the MAC result back through the WBR path. It generalises the single-shot macFirst/mac states to a parametrised element count, address step and operand width.

## Interface
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, operand/read-data width
- `LEN_W`, 8, vector length counter width (max `len` = 2^LEN_W−1)
- `ADDR_STEP`, 1, address increment per element
---
- `CLK`  in  1  clock
- `RESET`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_a`, `base_b`  in  ADDR_W  vector base addresses; latched on accepted `start`
- `len`  in  LEN_W  element count; latched on accepted `start`
- `busy`  in  1  memory busy (same meaning as in fetch/load)
- `mem_data`  in  DATA_W  memory read data
- `mem_addr`  out  ADDR_W  read address
- `MR`  out  1  memory read request
- `opA`, `opB`  out  DATA_W  registered operands to the MAC
- `MAC_EN`  out  1  MAC accumulate strobe
- `MAC_RST`  out  1  clear accumulator before this product
- `seq_busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`: zero length, or abort
- `STATE_o`  out  3  current state, for debug

## Operation
- States:
  - IDLE: `start` → RDA, or → DONE when `len`==0.
  - RDA: `MR`=1, `mem_addr`=`base_a`+`idx`·`ADDR_STEP`; on `~busy` capture `mem_data`→`opA`, → RDB; otherwise stay.
  - RDB: same, using `base_b`, capture into `opB`, → ACC.
  - ACC: `MAC_EN`=1; `MAC_RST`=1 only when `idx`==0; `idx`++. If `idx`+1==`len` → DONE, else → RDA.
  - DONE: `done`=1 → IDLE.
- Outputs are a Moore decode of the state register, except the RDA/RDB captures, which are qualified by `busy`.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- `idx` is LEN_W bits wide and is cleared on accepted `start`.
- `start` outside IDLE is ignored; it is not queued.
- `len`==0: no `MR`, no `MAC_EN`; DONE with `err`=1. The accumulator is left untouched.
- `err`=0 on normal completion.
- `opA`/`opB` hold their values between captures.

## Timing
- Reset values: state IDLE; `idx`, `opA`, `opB`, latched bases and `len` all 0; every output 0.
- `RESET` mid-operation: next cycle is IDLE with all outputs 0. No `done` is issued, and an in-flight read is dropped.
- Zero-wait memory: 3 cycles per element. `done` is high 3·`len`+1 cycles after the edge that accepts `start`.
- Each `busy` cycle in RDA/RDB adds exactly one cycle.
- `MAC_EN` and `opA`/`opB` are valid in the same cycle; the MAC samples them at the end of ACC.
- Back-to-back: `start` may be accepted in the cycle after DONE, i.e. the first IDLE cycle.

## Configuration
- `DLX_VMAC_ABORT_EN` defined: adds input `abort` (1 bit).
  - In RDA/RDB, `abort` forces → DONE with `err`=1, without waiting for `busy`.
  - In ACC, the product completes first, then → DONE with `err`=1.
  - `abort` in IDLE/DONE is ignored.
- Undefined: no `abort` port; behaviour is as above.

## Structure
- Package `dlx_vmac_pkg`: state encoding constants (IDLE=0, RDA=1, RDB=2, ACC=3, DONE=4) and default widths.
- One natural sub-module, `dlx_vmac_agu`: holds latched bases, the `idx` counter and the address mux; outputs `mem_addr` and `last` (`idx`+1==`len`).
- The FSM lives in the top module.

## Test plan
- `len`=3, `base_a`=0x100, `base_b`=0x200, `ADDR_STEP`=1, `busy`=0:
  - `mem_addr` sequence 0x100, 0x200, 0x101, 0x201, 0x102, 0x202.
  - `MAC_EN` pulses 3×; `MAC_RST` on the first only.
  - `done` at cycle 10, `err`=0.
- `len`=2 with `busy` held 2 cycles in every read → `done` at cycle 7+8=15; `opA`/`opB` equal the data present when `busy` fell.
- `len`=0 → `done`=1, `err`=1 one cycle after `start`; `MR` and `MAC_EN` never assert.
- `RESET` asserted in the second RDB → next cycle IDLE, all outputs 0, no `done`. A new `start` with `len`=1 completes in 4 cycles.
- `base_a`=0xFFFFFFFF, `len`=2 → second A address is 0x00000000.
- `start` asserted during ACC is ignored. With `DLX_VMAC_ABORT_EN`, `abort` in RDA → DONE next cycle, `err`=1, with `busy` still 1.
